// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Controller FSM for a write-back, write-allocate cache.
//               IDLE -> TAG_CHECK; a hit completes the CPU request in one
//               cycle. A miss writes the victim line back if it is dirty,
//               then fills the line from physical memory and re-checks.
//               Each physical-memory wait is bounded by TIMEOUT cycles. On
//               expiry the wait is abandoned and a sticky error flag is set.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : TIMEOUT  max cycles waiting for pmem_resp (1..65535)
// Macro       : CACHE_CTRL_PERF_EN  when defined, hit_count/miss_count are
//               live saturating counters. Otherwise both are tied to 0.
// Ports       : clk, rst_n (async, active-low)
//               CPU side   : mem_read, mem_write -> mem_resp
//               datapath   : hit, dirty -> load_data, load_tag, load_valid,
//                            load_dirty, dirty_in, addr_sel, data_sel
//               pmem side  : pmem_read, pmem_write <- pmem_resp
//               status     : error, hit_count[31:0], miss_count[31:0]
// ============================================================================
module cache_control #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit,
    input  logic        dirty,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    output logic        load_data,
    output logic        load_tag,
    output logic        load_valid,
    output logic        load_dirty,
    output logic        dirty_in,
    output logic        addr_sel,
    output logic        data_sel,
    output logic        error,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_TAG_CHECK = 2'd1;
    localparam logic [1:0] c_WRITEBACK = 2'd2;
    localparam logic [1:0] c_ALLOCATE  = 2'd3;

    // The counter starts at 0 on entry to a wait state. The last allowed
    // cycle is therefore the one where it reads TIMEOUT-1.
    localparam logic [15:0] c_WAIT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_wait_cnt;
    logic        r_error;
    logic        w_req;
    logic        w_in_wait;
    logic        w_timeout;

    // Simultaneous read and write requests are handled as a write.
    assign w_req     = mem_read | mem_write;
    assign w_in_wait = (r_state == c_WRITEBACK) || (r_state == c_ALLOCATE);
    // A response in the last allowed cycle still counts as success.
    assign w_timeout = w_in_wait && !pmem_resp && (r_wait_cnt == c_WAIT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_req) w_next_state = c_TAG_CHECK;
            end
            c_TAG_CHECK: begin
                if (!w_req)     w_next_state = c_IDLE;
                else if (hit)   w_next_state = c_IDLE;
                else if (dirty) w_next_state = c_WRITEBACK;
                else            w_next_state = c_ALLOCATE;
            end
            c_WRITEBACK: begin
                if (pmem_resp)      w_next_state = c_ALLOCATE;
                else if (w_timeout) w_next_state = c_IDLE;
            end
            c_ALLOCATE: begin
                if (pmem_resp)      w_next_state = c_TAG_CHECK;
                else if (w_timeout) w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_data  = 1'b0;
        load_tag   = 1'b0;
        load_valid = 1'b0;
        load_dirty = 1'b0;
        dirty_in   = 1'b0;
        addr_sel   = 1'b0;
        data_sel   = 1'b0;
        case (r_state)
            c_TAG_CHECK: begin
                if (w_req && hit) begin
                    mem_resp = 1'b1;
                    if (mem_write) begin
                        load_data  = 1'b1;
                        load_dirty = 1'b1;
                        dirty_in   = 1'b1;
                    end
                end
            end
            c_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
            end
            c_ALLOCATE: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    load_valid = 1'b1;
                    load_dirty = 1'b1;
                    data_sel   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Wait counter: cleared on entry to each wait state (including the
    // WRITEBACK -> ALLOCATE hand-over), counts cycles without a response.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 16'd0;
        end else if ((w_next_state != r_state) &&
                     ((w_next_state == c_WRITEBACK) || (w_next_state == c_ALLOCATE))) begin
            r_wait_cnt <= 16'd0;
        end else if (w_in_wait && !pmem_resp) begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
        end
    end

    // Sticky until reset. It does not gate new requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (w_timeout) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef CACHE_CTRL_PERF_EN
    logic        w_hit_event;
    logic        w_miss_event;
    logic [31:0] r_hit_count;
    logic [31:0] r_miss_count;

    // The re-check after a fill reaches TAG_CHECK again and counts as a hit.
    assign w_hit_event  = (r_state == c_TAG_CHECK) && w_req && hit;
    assign w_miss_event = (r_state == c_TAG_CHECK) && w_req && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= 32'd0;
            r_miss_count <= 32'd0;
        end else begin
            if (w_hit_event && (r_hit_count != 32'hFFFF_FFFF)) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_miss_event && (r_miss_count != 32'hFFFF_FFFF)) begin
                r_miss_count <= r_miss_count + 32'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_control
// Description : Directed self-checking bench for cache_control (TIMEOUT=4).
//               Inputs change 2 time units after a rising edge. Outputs are
//               sampled 1 unit later, mid-cycle.
//               The output vector is ordered
//               {mem_resp, pmem_read, pmem_write, load_data, load_tag,
//                load_valid, load_dirty, dirty_in, addr_sel, data_sel}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control;

    localparam int unsigned c_TIMEOUT = 4;
`ifdef CACHE_CTRL_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    localparam logic [9:0] c_O_NONE  = 10'b0000000000;
    localparam logic [9:0] c_O_RHIT  = 10'b1000000000;
    localparam logic [9:0] c_O_WHIT  = 10'b1001001100;
    localparam logic [9:0] c_O_WB    = 10'b0010000010;
    localparam logic [9:0] c_O_ALLOC = 10'b0100000000;
    localparam logic [9:0] c_O_FILL  = 10'b0101111001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, hit, dirty, pmem_resp;
    logic        mem_resp, pmem_read, pmem_write;
    logic        load_data, load_tag, load_valid, load_dirty, dirty_in;
    logic        addr_sel, data_sel, error;
    logic [31:0] hit_count, miss_count;
    logic [9:0]  outs;

    int checks = 0;
    int fails  = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    assign outs = {mem_resp, pmem_read, pmem_write, load_data, load_tag,
                   load_valid, load_dirty, dirty_in, addr_sel, data_sel};

    always #5 clk = ~clk;

    cache_control #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_resp   (mem_resp),
        .hit        (hit),
        .dirty      (dirty),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_resp  (pmem_resp),
        .load_data  (load_data),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .dirty_in   (dirty_in),
        .addr_sel   (addr_sel),
        .data_sel   (data_sel),
        .error      (error),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b1; mem_write = 1'b0; hit = 1'b1;
        dirty = 1'b0; pmem_resp = 1'b0;
        #1;
        checks++;
        if (outs !== c_O_NONE || error !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: outs=%b err=%b hc=%0d mc=%0d, want outs=%b err=0 hc=0 mc=0",
                     outs, error, hit_count, miss_count, c_O_NONE);
        end
        tick();
        #1;
        checks++;
        if (outs !== c_O_NONE) begin
            fails++;
            $display("FAIL reset_held: outs=%b want %b", outs, c_O_NONE);
        end
        mem_read = 1'b0; hit = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_read_hit();
        tick();
        mem_read = 1'b1; hit = 1'b1; #1;
        checks++;
        if (outs !== c_O_NONE) begin
            fails++; $display("FAIL rh_idle: outs=%b want %b", outs, c_O_NONE);
        end
        tick(); #1;
        checks++;
        if (outs !== c_O_RHIT) begin
            fails++; $display("FAIL rh_resp: outs=%b want %b", outs, c_O_RHIT);
        end
        tick(); mem_read = 1'b0; hit = 1'b0; #1;
        exp_hits++;
        checks++;
        if (outs !== c_O_NONE || hit_count !== (c_PERF ? 32'(exp_hits) : 32'd0)) begin
            fails++;
            $display("FAIL rh_done: outs=%b hc=%0d want outs=%b hc=%0d",
                     outs, hit_count, c_O_NONE, c_PERF ? exp_hits : 0);
        end
    endtask

    // rd=1 with wr=1 exercises the "both high behaves as a write" rule.
    task automatic test_write_hit(input logic rd);
        mem_write = 1'b1; mem_read = rd; hit = 1'b1;
        tick(); #1;
        checks++;
        if (outs !== c_O_WHIT) begin
            fails++; $display("FAIL wh_resp(rd=%0b): outs=%b want %b", rd, outs, c_O_WHIT);
        end
        tick(); mem_write = 1'b0; mem_read = 1'b0; hit = 1'b0; #1;
        exp_hits++;
        checks++;
        if (outs !== c_O_NONE || hit_count !== (c_PERF ? 32'(exp_hits) : 32'd0)) begin
            fails++;
            $display("FAIL wh_done(rd=%0b): outs=%b hc=%0d want outs=%b hc=%0d",
                     rd, outs, hit_count, c_O_NONE, c_PERF ? exp_hits : 0);
        end
    endtask

    task automatic test_withdraw();
        mem_read = 1'b1; hit = 1'b0;
        tick();
        mem_read = 1'b0; hit = 1'b1; #1;
        checks++;
        if (outs !== c_O_NONE) begin
            fails++; $display("FAIL wd_tag: outs=%b want %b", outs, c_O_NONE);
        end
        tick(); hit = 1'b0; tick(); #1;
        checks++;
        if (outs !== c_O_NONE || hit_count !== (c_PERF ? 32'(exp_hits) : 32'd0) ||
            miss_count !== (c_PERF ? 32'(exp_misses) : 32'd0)) begin
            fails++;
            $display("FAIL wd_idle: outs=%b hc=%0d mc=%0d want outs=%b hc=%0d mc=%0d",
                     outs, hit_count, miss_count, c_O_NONE,
                     c_PERF ? exp_hits : 0, c_PERF ? exp_misses : 0);
        end
    endtask

    task automatic test_dirty_miss();
        mem_read = 1'b1; hit = 1'b0; dirty = 1'b1;
        tick(); #1;
        checks++;
        if (outs !== c_O_NONE) begin
            fails++; $display("FAIL dm_tag: outs=%b want %b", outs, c_O_NONE);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); pmem_resp = (i == 2); #1;
            checks++;
            if (outs !== c_O_WB) begin
                fails++; $display("FAIL dm_wb%0d: outs=%b want %b", i, outs, c_O_WB);
            end
        end
        dirty = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); pmem_resp = (i == 2); #1;
            checks++;
            if (outs !== ((i == 2) ? c_O_FILL : c_O_ALLOC)) begin
                fails++;
                $display("FAIL dm_alloc%0d: outs=%b want %b", i, outs,
                         (i == 2) ? c_O_FILL : c_O_ALLOC);
            end
        end
        tick(); pmem_resp = 1'b0; hit = 1'b1; #1;
        checks++;
        if (outs !== c_O_RHIT) begin
            fails++; $display("FAIL dm_recheck: outs=%b want %b", outs, c_O_RHIT);
        end
        tick(); mem_read = 1'b0; hit = 1'b0; #1;
        exp_hits++; exp_misses++;
        checks++;
        if (outs !== c_O_NONE || error !== 1'b0 ||
            hit_count !== (c_PERF ? 32'(exp_hits) : 32'd0) ||
            miss_count !== (c_PERF ? 32'(exp_misses) : 32'd0)) begin
            fails++;
            $display("FAIL dm_done: outs=%b err=%b hc=%0d mc=%0d want outs=%b err=0 hc=%0d mc=%0d",
                     outs, error, hit_count, miss_count, c_O_NONE,
                     c_PERF ? exp_hits : 0, c_PERF ? exp_misses : 0);
        end
    endtask

    // Response arrives in the last allowed allocate cycle: a success.
    task automatic test_resp_at_timeout();
        mem_read = 1'b1; hit = 1'b0; dirty = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); pmem_resp = (i == 3); #1;
            checks++;
            if (outs !== ((i == 3) ? c_O_FILL : c_O_ALLOC)) begin
                fails++;
                $display("FAIL rt_alloc%0d: outs=%b want %b", i, outs,
                         (i == 3) ? c_O_FILL : c_O_ALLOC);
            end
        end
        tick(); pmem_resp = 1'b0; hit = 1'b1; #1;
        checks++;
        if (outs !== c_O_RHIT || error !== 1'b0) begin
            fails++;
            $display("FAIL rt_recheck: outs=%b err=%b want outs=%b err=0", outs, error, c_O_RHIT);
        end
        tick(); mem_read = 1'b0; hit = 1'b0;
        exp_hits++; exp_misses++;
    endtask

    task automatic test_pmem_resp_ignored();
        pmem_resp = 1'b1;
        tick(); tick(); #1;
        checks++;
        if (outs !== c_O_NONE || error !== 1'b0) begin
            fails++;
            $display("FAIL pr_ignored: outs=%b err=%b want outs=%b err=0", outs, error, c_O_NONE);
        end
        pmem_resp = 1'b0;
    endtask

    task automatic test_timeout();
        mem_read = 1'b1; hit = 1'b0; dirty = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            checks++;
            if (outs !== c_O_ALLOC) begin
                fails++; $display("FAIL to_alloc%0d: outs=%b want %b", i, outs, c_O_ALLOC);
            end
        end
        tick(); mem_read = 1'b0; #1;
        exp_misses++;
        checks++;
        if (outs !== c_O_NONE || error !== 1'b1 ||
            miss_count !== (c_PERF ? 32'(exp_misses) : 32'd0)) begin
            fails++;
            $display("FAIL to_abort: outs=%b err=%b mc=%0d want outs=%b err=1 mc=%0d",
                     outs, error, miss_count, c_O_NONE, c_PERF ? exp_misses : 0);
        end
        tick(); #1;
        checks++;
        if (outs !== c_O_NONE) begin
            fails++; $display("FAIL to_idle: outs=%b want %b", outs, c_O_NONE);
        end
    endtask

    task automatic test_error_no_block();
        mem_read = 1'b1; hit = 1'b1;
        tick(); #1;
        checks++;
        if (outs !== c_O_RHIT || error !== 1'b1) begin
            fails++;
            $display("FAIL eb_hit: outs=%b err=%b want outs=%b err=1", outs, error, c_O_RHIT);
        end
        tick(); mem_read = 1'b0; hit = 1'b0;
        exp_hits++;
    endtask

    task automatic test_reset_mid_wb();
        mem_read = 1'b1; hit = 1'b0; dirty = 1'b1;
        tick(); tick(); tick(); #1;
        checks++;
        if (outs !== c_O_WB) begin
            fails++; $display("FAIL rw_wb2: outs=%b want %b", outs, c_O_WB);
        end
        rst_n = 1'b0; mem_read = 1'b0; dirty = 1'b0; #1;
        checks++;
        if (outs !== c_O_NONE || error !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            fails++;
            $display("FAIL rw_async: outs=%b err=%b hc=%0d mc=%0d want outs=%b err=0 hc=0 mc=0",
                     outs, error, hit_count, miss_count, c_O_NONE);
        end
        #1 rst_n = 1'b1;
        exp_hits = 0; exp_misses = 0;
        tick(); mem_read = 1'b1; hit = 1'b1;
        tick(); #1;
        checks++;
        if (outs !== c_O_RHIT) begin
            fails++; $display("FAIL rw_hit: outs=%b want %b", outs, c_O_RHIT);
        end
        tick(); mem_read = 1'b0; hit = 1'b0; #1;
        exp_hits++;
        checks++;
        if (outs !== c_O_NONE || error !== 1'b0 || hit_count !== (c_PERF ? 32'(exp_hits) : 32'd0)) begin
            fails++;
            $display("FAIL rw_done: outs=%b err=%b hc=%0d want outs=%b err=0 hc=%0d",
                     outs, error, hit_count, c_O_NONE, c_PERF ? exp_hits : 0);
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_hit(1'b0);
        test_write_hit(1'b1);
        test_withdraw();
        test_dirty_miss();
        test_resp_at_timeout();
        test_pmem_resp_ignored();
        test_timeout();
        test_error_no_block();
        test_reset_mid_wb();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have parameter: TIMEOUT, 255, max cycles to wait for pmem_resp in WRITEBACK/ALLOCATE before abort (1..65535).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: mem_read  input  1  CPU read request, held until mem_resp.
REQ-005 SHALL have port: mem_write  input  1  CPU write request, held until mem_resp.
REQ-006 SHALL have port: mem_resp  output  1  one-cycle CPU completion pulse.
REQ-007 SHALL have port: hit  input  1  tag-match AND valid for the indexed set, from the datapath.
REQ-008 SHALL have port: dirty  input  1  dirty-array output for the indexed set.
REQ-009 SHALL have port: pmem_read / pmem_write  output  1 each  physical-memory line read/write strobes.
REQ-010 SHALL have port: pmem_resp  input  1  physical-memory completion.
REQ-011 SHALL have port: load_data, load_tag, load_valid, load_dirty  output  1 each  array write enables.
REQ-012 SHALL have port: dirty_in  output  1  value written into the dirty array.
REQ-013 SHALL have port: addr_sel  output  1  pmem address mux; 0 = CPU address, 1 = {stored tag, index}.
REQ-014 SHALL have port: data_sel  output  1  data-array input mux; 0 = CPU write merge, 1 = pmem line.
REQ-015 SHALL have port: error  output  1  sticky pmem-timeout flag.
REQ-016 SHALL have port: hit_count, miss_count  output  32 each  performance counters.

Function
REQ-017 SHALL implement states IDLE, TAG_CHECK, WRITEBACK, ALLOCATE; all outputs not named for a state SHALL be 0 in it.
REQ-018 IDLE: mem_read|mem_write -> TAG_CHECK next cycle; else stay.
REQ-019 TAG_CHECK, hit: mem_resp=1 this cycle; on write also load_data=1, load_dirty=1, dirty_in=1, data_sel=0; -> IDLE.
REQ-020 TAG_CHECK, miss & dirty: -> WRITEBACK; miss & clean: -> ALLOCATE; no mem_resp.
REQ-021 TAG_CHECK, both requests low (withdrawn): -> IDLE, no strobes, no counter update.
REQ-022 mem_read and mem_write both high SHALL be treated as a write.
REQ-023 WRITEBACK: pmem_write=1, addr_sel=1 until pmem_resp; on pmem_resp -> ALLOCATE.
REQ-024 ALLOCATE: pmem_read=1, addr_sel=0; on pmem_resp: load_data=1, load_tag=1, load_valid=1, load_dirty=1, dirty_in=0, data_sel=1 in that cycle; -> TAG_CHECK.
REQ-025 Hit latency: request sampled in IDLE at edge N, mem_resp high during cycle N+1; miss latency = 1 + writeback wait + allocate wait + 1 cycles.
REQ-026 A wait counter SHALL clear on entry to WRITEBACK/ALLOCATE and increment each cycle without pmem_resp; on reaching TIMEOUT: strobes drop, error<=1, -> IDLE, no mem_resp.
REQ-027 pmem_resp arriving in the same cycle the counter reaches TIMEOUT SHALL count as success (no error).
REQ-028 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-029 error SHALL remain 1 until reset; it SHALL NOT block further requests.
REQ-030 hit_count SHALL increment on each TAG_CHECK hit with mem_resp; miss_count on each TAG_CHECK->WRITEBACK/ALLOCATE transition; both saturate at 0xFFFFFFFF; the re-check after fill counts as a hit.

Reset
REQ-031 rst_n low SHALL immediately (asynchronously) force IDLE, wait counter 0, error 0, counters 0, and all outputs 0, including mid-WRITEBACK/ALLOCATE.
REQ-032 After rst_n rises, the first request SHALL be sampled no earlier than the next rising edge.

Configuration
REQ-033 Macro CACHE_CTRL_PERF_EN defined: hit_count/miss_count SHALL behave per REQ-030.
REQ-034 CACHE_CTRL_PERF_EN undefined: ports SHALL remain, tied to constant 0, no counter registers; all other behaviour identical.

Verification
REQ-035 Read hit: mem_read=1, hit=1 at edge 0 -> mem_resp=1 in cycle 1 only, all load_* 0, hit_count=1.
REQ-036 Write hit: mem_write=1, hit=1 -> cycle 1: mem_resp=1, load_data=1, load_dirty=1, dirty_in=1, data_sel=0.
REQ-037 Dirty read miss, pmem_resp after 3 cycles each -> pmem_write 3 cycles with addr_sel=1, then pmem_read 3 cycles with addr_sel=0, fill enables with data_sel=1, then hit -> mem_resp; miss_count=1, hit_count=1.
REQ-038 Clean miss, pmem_resp never, TIMEOUT=4 -> pmem_read high 4 cycles, then drop, error=1, state IDLE, no mem_resp.
REQ-039 rst_n low in the 2nd WRITEBACK cycle -> pmem_write 0 same cycle without clock edge; after release, read hit completes in 2 cycles, error=0.
REQ-040 Build without CACHE_CTRL_PERF_EN, run REQ-037 -> hit_count=miss_count=0, all other outputs identical.
